ntt_pingpong_buffer: RTL and testbench

- Coefficient storage stage around ntt_memory_wrapper: two polynomial banks of 2^LOGN x LOGQ words.
- Host streams a polynomial into one bank while the NTT reads and writes the other bank in place.
- Finished banks are streamed back out to the host.
- Generates the wrapper's start and re-arm reset, because the wrapper's finish stays high until it is reset.

---
 rtl/ntt_pingpong_buffer.sv | 129 ++++++++++++
 tb/tb_ntt_pingpong_buffer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_pingpong_buffer.sv
// ntt_pingpong_buffer: two-bank coefficient store between host load/unload streams and the NTT wrapper.
// Define NTT_BITREV_UNLOAD_EN to unload each bank in bit-reversed address order.
module ntt_pingpong_buffer #(
  parameter int LOGN = 12,
  parameter int LOGQ = 64,
  parameter int AW = (LOGN < 9 ? 10 : LOGN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [LOGQ-1:0] ld_data,
  output logic            ul_valid,
  input  logic            ul_ready,
  output logic [LOGQ-1:0] ul_data,
  output logic            ul_last,
  output logic            ntt_rst,
  output logic            ntt_start,
  output logic            ntt_intt_busy,
  input  logic [AW-1:0]   ntt_read_address,
  input  logic [AW-1:0]   ntt_write_address,
  input  logic            ntt_wea,
  input  logic [LOGQ-1:0] ntt_data_in,
  output logic [LOGQ-1:0] ntt_data_out,
  input  logic            ntt_finish
);
  localparam int N = 1 << LOGN;
  typedef enum logic [2:0] {EMPTY, LOADING, FULL, COMPUTING, DONE, UNLOADING} bank_t;
  typedef enum logic [1:0] {IDLE, START, RUN, REARM} eng_t;
  bank_t st [2];
  eng_t eng;
  logic lptr, cptr, uptr, rearm;
  logic [LOGN-1:0] lcnt, ucnt, useq;
  logic ld_fire, ul_fire, ntt_we;

  function automatic logic [LOGN-1:0] ul_addr(input logic [LOGN-1:0] a);
    logic [LOGN-1:0] r;
`ifdef NTT_BITREV_UNLOAD_EN
    for (int i = 0; i < LOGN; i++) r[i] = a[LOGN-1-i];
`else
    r = a;
`endif
    return r;
  endfunction

  assign ld_ready = !rst && (st[lptr] == EMPTY || st[lptr] == LOADING);
  assign ul_valid = !rst && st[uptr] == UNLOADING;
  assign ul_last = ul_valid && &ucnt;
  assign ld_fire = ld_valid && ld_ready;
  assign ul_fire = ul_valid && ul_ready;
  assign ntt_we = ntt_wea && ntt_intt_busy;
  assign ntt_rst = rst || rearm;
  // unload reads one word ahead so a transfer is followed by the next word with no bubble
  assign useq = ul_fire ? ucnt + 1'b1 : ucnt;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [LOGQ-1:0] mem [N];
    logic [LOGQ-1:0] rd, wd;
    logic [LOGN-1:0] wa, ra;
    logic ld_sel, we;
    always_comb begin
      ld_sel = st[b] == EMPTY || st[b] == LOADING;
      we = ld_sel ? ld_fire && lptr == 1'(b) : ntt_we && cptr == 1'(b);
      wa = ld_sel ? lcnt : ntt_write_address[LOGN-1:0];
      wd = ld_sel ? ld_data : ntt_data_in;
      ra = (st[b] == DONE || st[b] == UNLOADING) ? ul_addr(useq) : ntt_read_address[LOGN-1:0];
    end
    always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
      rd <= mem[ra];
    end
  end

  if (AW > LOGN) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^{ntt_read_address[AW-1:LOGN], ntt_write_address[AW-1:LOGN]};
  end

  assign ntt_data_out = ntt_intt_busy ? (cptr ? g_bank[1].rd : g_bank[0].rd) : '0;
  assign ul_data = ul_valid ? (uptr ? g_bank[1].rd : g_bank[0].rd) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      st[0] <= EMPTY;
      st[1] <= EMPTY;
      eng <= IDLE;
      {lptr, cptr, uptr, rearm, ntt_start, ntt_intt_busy} <= '0;
      lcnt <= '0;
      ucnt <= '0;
    end else begin
      if (ld_fire) begin
        st[lptr] <= &lcnt ? FULL : LOADING;
        lcnt <= lcnt + 1'b1;
        if (&lcnt) lptr <= !lptr;
      end
      case (eng)
        IDLE: if (st[cptr] == FULL) begin
          ntt_start <= 1'b1;
          eng <= START;
        end
        START: begin
          st[cptr] <= COMPUTING;
          ntt_start <= 1'b0;
          ntt_intt_busy <= 1'b1;
          eng <= RUN;
        end
        RUN: if (ntt_finish) begin
          ntt_intt_busy <= 1'b0;
          rearm <= 1'b1;
          eng <= REARM;
        end
        default: begin
          st[cptr] <= DONE;
          cptr <= !cptr;
          rearm <= 1'b0;
          eng <= IDLE;
        end
      endcase
      if (st[uptr] == DONE) st[uptr] <= UNLOADING;
      if (ul_fire) begin
        ucnt <= ucnt + 1'b1;
        if (&ucnt) begin
          st[uptr] <= EMPTY;
          uptr <= !uptr;
        end
      end
    end
  end
endmodule

// File: tb/tb_ntt_pingpong_buffer.sv
// tb_ntt_pingpong_buffer: random-stimulus bench with a stub NTT engine and a stream-level reference model.
module tb_ntt_pingpong_buffer;
`ifdef NTT_BITREV_UNLOAD_EN
  localparam int LOGN = 3;
`else
  localparam int LOGN = 4;
`endif
  localparam int LOGQ = 64;
  localparam int AW = 10;
  localparam int N = 1 << LOGN;
  typedef logic [LOGQ-1:0] poly_t [N];

  logic clk = 0, rst, ld_valid, ld_ready, ul_valid, ul_ready, ul_last;
  logic ntt_rst, ntt_start, ntt_intt_busy, ntt_wea, ntt_finish;
  logic [LOGQ-1:0] ld_data, ul_data, ntt_data_in, ntt_data_out;
  logic [AW-1:0] ntt_read_address, ntt_write_address;
  int n_chk = 0, n_fail = 0;
  int mode = 0, gap = 0, cyc = 0, stub_w = 0;
  logic [LOGQ-1:0] k_add = '0;
  logic [LOGQ-1:0] got [$], expq [$];
  bit lastq [$];
  int start_t [$], rearm_t [$];

  always #5 clk = ~clk;

  ntt_pingpong_buffer #(.LOGN(LOGN), .LOGQ(LOGQ)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ul_valid(ul_valid), .ul_ready(ul_ready), .ul_data(ul_data), .ul_last(ul_last),
    .ntt_rst(ntt_rst), .ntt_start(ntt_start), .ntt_intt_busy(ntt_intt_busy),
    .ntt_read_address(ntt_read_address), .ntt_write_address(ntt_write_address),
    .ntt_wea(ntt_wea), .ntt_data_in(ntt_data_in), .ntt_data_out(ntt_data_out),
    .ntt_finish(ntt_finish)
  );

  // pulse monitor: cycle stamps of start pulses and of re-arm pulses outside host reset
  initial forever begin
    @(negedge clk);
    #1;
    cyc++;
    if (ntt_start) start_t.push_back(cyc);
    if (ntt_rst && !rst) rearm_t.push_back(cyc);
  end

  // host unload sink: mode 0 stalls, 1 always ready, 2 random ready
  initial begin
    ul_ready = 0;
    forever begin
      @(negedge clk);
      ul_ready = mode == 1 ? 1'b1 : mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
      if (ul_valid && ul_ready) begin
        got.push_back(ul_data);
        lastq.push_back(ul_last);
      end
    end
  end

  // stub NTT: reads each address, writes back value + k_add to the same address, then raises finish
  initial begin
    int s_i, s_ph, s_dly;
    bit s_act;
    s_act = 0; s_i = 0; s_ph = 0; s_dly = 0;
    ntt_wea = 0; ntt_finish = 0; ntt_read_address = '0; ntt_write_address = '0; ntt_data_in = '0;
    forever begin
      @(negedge clk);
      if (ntt_rst) begin
        s_act = 0; ntt_finish = 0; ntt_wea = 0;
      end else if (ntt_start) begin
        s_act = 1; s_i = 0; s_ph = 0; s_dly = 0; stub_w = 0;
      end else if (s_act) begin
        ntt_wea = 0;
        if (s_dly > 0) s_dly--;
        else if (s_ph == 0) begin
          ntt_read_address = AW'(s_i);
          s_ph = 1;
        end else if (s_i < N) begin
          ntt_wea = 1;
          ntt_write_address = AW'(s_i);
          ntt_data_in = ntt_data_out + k_add;
          s_i++; stub_w++; s_ph = 0; s_dly = gap;
        end else begin
          ntt_finish = 1;
          s_act = 0;
        end
      end
    end
  end

  function automatic int addr_of(int j);
    int r;
    r = j;
`ifdef NTT_BITREV_UNLOAD_EN
    r = 0;
    for (int b = 0; b < LOGN; b++) r = r * 2 + ((j >> b) & 1);
`endif
    return r;
  endfunction

  task automatic rand_poly(output poly_t v);
    for (int i = 0; i < N; i++) v[i] = {$urandom, $urandom};
  endtask

  task automatic push_expect(input poly_t v);
    for (int j = 0; j < N; j++) expq.push_back(v[addr_of(j)] + k_add);
  endtask

  task automatic load_poly(input poly_t v, output int bubbles, output bit ok);
    int i, t;
    i = 0; t = 0; bubbles = 0;
    while (i < N && t < 3000) begin
      ld_valid = 1;
      ld_data = v[i];
      if (ld_ready) i++; else bubbles++;
      t++;
      @(negedge clk);
    end
    ld_valid = 0;
    ok = i == N;
  endtask

  task automatic wait_out(input int n, output bit ok);
    int t;
    t = 0;
    while (got.size() < n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    ok = got.size() == n;
  endtask

  task automatic clear_q();
    got.delete(); lastq.delete(); expq.delete();
  endtask

  task automatic test_reset();
    rst = 1; ld_valid = 0; ld_data = '0;
    repeat (3) @(negedge clk);
    n_chk++; if (ntt_rst !== 1'b1) begin n_fail++; $display("FAIL reset ntt_rst: got %b expected 1", ntt_rst); end
    n_chk++; if ({ntt_start, ntt_intt_busy, ul_valid, ul_last, ld_ready} !== 5'b0) begin
      n_fail++; $display("FAIL reset flags: got start/busy/ulv/last/ldr=%b expected 00000", {ntt_start, ntt_intt_busy, ul_valid, ul_last, ld_ready}); end
    n_chk++; if (ntt_data_out !== '0 || ul_data !== '0) begin n_fail++; $display("FAIL reset data: got %h %h expected 0", ntt_data_out, ul_data); end
    rst = 0;
    #1;
    n_chk++; if (ld_ready !== 1'b1 || ntt_rst !== 1'b0) begin n_fail++; $display("FAIL reset release: got ld_ready=%b ntt_rst=%b expected 1 0", ld_ready, ntt_rst); end
    @(negedge clk);
  endtask

  task automatic test_single();
    poly_t v; int b, s0, r0; bit ok;
    mode = 1; k_add = '0; gap = 0;
    s0 = start_t.size(); r0 = rearm_t.size();
    for (int i = 0; i < N; i++) v[i] = LOGQ'(i + 1);
    push_expect(v);
    load_poly(v, b, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL single load: not all %0d words accepted", N); end
    wait_out(N, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL single count: got %0d words expected %0d", got.size(), N); end
    n_chk++; if (start_t.size() - s0 != 1) begin n_fail++; $display("FAIL single starts: got %0d expected 1", start_t.size() - s0); end
    n_chk++; if (rearm_t.size() - r0 != 1 || rearm_t[r0] <= start_t[s0]) begin
      n_fail++; $display("FAIL single rearm: got %0d pulses expected 1 after start", rearm_t.size() - r0); end
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      n_chk++;
      if (got[i] !== expq[i] || lastq[i] !== (i % N == N - 1)) begin
        n_fail++; $display("FAIL single word %0d: got %h last=%0b expected %h last=%0b", i, got[i], lastq[i], expq[i], i % N == N - 1); end
    end
    clear_q();
  endtask

  task automatic test_back_to_back();
    poly_t a, c; int ba, bb, s0, r0; bit oka, okb, ok;
    mode = 1; k_add = {$urandom, $urandom}; gap = 3;
    s0 = start_t.size(); r0 = rearm_t.size();
    rand_poly(a); rand_poly(c);
    push_expect(a); push_expect(c);
    load_poly(a, ba, oka);
    load_poly(c, bb, okb);
    n_chk++; if (!oka || !okb || ba + bb != 0) begin
      n_fail++; $display("FAIL b2b ld_ready: got %0d bubbles over %0d words expected 0", ba + bb, 2 * N); end
    wait_out(2 * N, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL b2b count: got %0d words expected %0d", got.size(), 2 * N); end
    n_chk++; if (start_t.size() - s0 != 2 || rearm_t.size() - r0 != 2 || start_t[s0 + 1] <= rearm_t[r0]) begin
      n_fail++; $display("FAIL b2b start order: starts=%0d rearms=%0d expected second start after first rearm", start_t.size() - s0, rearm_t.size() - r0); end
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      n_chk++;
      if (got[i] !== expq[i] || lastq[i] !== (i % N == N - 1)) begin
        n_fail++; $display("FAIL b2b word %0d: got %h last=%0b expected %h last=%0b", i, got[i], lastq[i], expq[i], i % N == N - 1); end
    end
    clear_q();
  endtask

  task automatic test_stall();
    poly_t a, c, d; int b, r0, t; bit ok;
    logic [LOGQ-1:0] d0;
    mode = 0; k_add = {$urandom, $urandom}; gap = 1;
    r0 = rearm_t.size();
    rand_poly(a); rand_poly(c); rand_poly(d);
    push_expect(a); push_expect(c); push_expect(d);
    load_poly(a, b, ok);
    load_poly(c, b, ok);
    t = 0;
    while (rearm_t.size() - r0 < 2 && t < 3000) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    n_chk++; if (rearm_t.size() - r0 != 2) begin n_fail++; $display("FAIL stall compute: got %0d rearms expected 2", rearm_t.size() - r0); end
    d0 = ul_data;
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (ld_ready !== 1'b0 || ul_valid !== 1'b1 || ul_last !== 1'b0 || ul_data !== expq[0] || ul_data !== d0) begin
        n_fail++; $display("FAIL stall hold %0d: got ld_ready=%b ul_valid=%b data=%h expected 0 1 %h", i, ld_ready, ul_valid, ul_data, expq[0]); end
      @(negedge clk);
    end
    mode = 1;
    load_poly(d, b, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL stall third load: not accepted after release"); end
    wait_out(3 * N, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL stall count: got %0d words expected %0d", got.size(), 3 * N); end
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      n_chk++;
      if (got[i] !== expq[i] || lastq[i] !== (i % N == N - 1)) begin
        n_fail++; $display("FAIL stall word %0d: got %h last=%0b expected %h last=%0b", i, got[i], lastq[i], expq[i], i % N == N - 1); end
    end
    clear_q();
  endtask

  task automatic test_reset_mid();
    poly_t a; int b, t; bit ok;
    mode = 1; k_add = {$urandom, $urandom}; gap = 2; stub_w = 0;
    rand_poly(a);
    load_poly(a, b, ok);
    t = 0;
    while (stub_w < N / 2 && t < 2000) begin @(negedge clk); t++; end
    n_chk++; if (stub_w < N / 2 || ntt_intt_busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid reach: got %0d writes busy=%b expected >=%0d and 1", stub_w, ntt_intt_busy, N / 2); end
    rst = 1;
    @(negedge clk);
    n_chk++; if (ntt_rst !== 1'b1 || ul_valid !== 1'b0 || ntt_intt_busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid state: got ntt_rst=%b ul_valid=%b busy=%b expected 1 0 0", ntt_rst, ul_valid, ntt_intt_busy); end
    @(negedge clk);
    rst = 0;
    #1;
    n_chk++; if (ld_ready !== 1'b1 || ntt_rst !== 1'b0) begin
      n_fail++; $display("FAIL rstmid release: got ld_ready=%b ntt_rst=%b expected 1 0", ld_ready, ntt_rst); end
    @(negedge clk);
    clear_q();
    k_add = {$urandom, $urandom}; gap = 0;
    rand_poly(a);
    push_expect(a);
    load_poly(a, b, ok);
    wait_out(N, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rstmid count: got %0d words expected %0d", got.size(), N); end
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      n_chk++;
      if (got[i] !== expq[i] || lastq[i] !== (i % N == N - 1)) begin
        n_fail++; $display("FAIL rstmid word %0d: got %h last=%0b expected %h last=%0b", i, got[i], lastq[i], expq[i], i % N == N - 1); end
    end
    clear_q();
  endtask

  task automatic test_random_ready();
    poly_t a; int b; bit ok;
    mode = 2; k_add = {$urandom, $urandom}; gap = $urandom_range(0, 2);
    for (int p = 0; p < 3; p++) begin
      rand_poly(a);
      push_expect(a);
      load_poly(a, b, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL random load %0d: not accepted", p); end
    end
    wait_out(3 * N, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL random count: got %0d words expected %0d", got.size(), 3 * N); end
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      n_chk++;
      if (got[i] !== expq[i] || lastq[i] !== (i % N == N - 1)) begin
        n_fail++; $display("FAIL random word %0d: got %h last=%0b expected %h last=%0b", i, got[i], lastq[i], expq[i], i % N == N - 1); end
    end
    clear_q();
  endtask

`ifdef NTT_BITREV_UNLOAD_EN
  task automatic test_bitrev();
    poly_t v; int b; bit ok;
    int exp8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    mode = 1; k_add = '0; gap = 0;
    for (int i = 0; i < N; i++) v[i] = LOGQ'(i);
    load_poly(v, b, ok);
    wait_out(N, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL bitrev count: got %0d words expected %0d", got.size(), N); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      n_chk++;
      if (got[i] !== LOGQ'(exp8[i]) || lastq[i] !== (i == 7)) begin
        n_fail++; $display("FAIL bitrev word %0d: got %0d last=%0b expected %0d last=%0b", i, got[i], lastq[i], exp8[i], i == 7); end
    end
    clear_q();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random_ready();
`ifdef NTT_BITREV_UNLOAD_EN
    test_bitrev();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
